// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel-format enum, delay-line record and the
// pixel expansion helpers used by the window painter.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef enum logic [1:0] {
    GRAY8  = 2'd0,
    RGB332 = 2'd1,
    RGB565 = 2'd2
  } pixel_mode_t;

  // Everything that must stay aligned with the pixel while the RAM is read.
  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       nblank;
    logic       frame_start;
    logic       show;
    logic [9:0] x;
    logic [9:0] y;
  } side_t;

  localparam side_t SIDE_IDLE = side_t'({1'b1, 1'b1, 23'd0});

  function automatic logic [23:0] expand_gray8(input logic [7:0] d);
    return {d, d, d};
  endfunction

  function automatic logic [23:0] expand_rgb332(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
  endfunction

  function automatic logic [23:0] expand_rgb565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  function automatic logic [23:0] expand_pixel(input pixel_mode_t m, input logic [15:0] d);
    case (m)
      RGB332:  return expand_rgb332(d[7:0]);
      RGB565:  return expand_rgb565(d);
      default: return expand_gray8(d[7:0]);
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with raw (undelayed) sync and active decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       line_end,
  output logic       frame_end
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (line_end) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h         = h_q;
  assign v         = v_q;
  assign line_end  = (h_q == H_LAST);
  assign frame_end = line_end && (v_q == V_LAST);
  assign hsync     = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
  assign vsync     = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
  assign active    = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: rtl/image_window_painter.sv
// VGA painter: shows a zoomed image from a synchronous pixel RAM inside a window,
// background elsewhere; all outputs delayed together to absorb RAM latency.
module image_window_painter
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE = VGA_H_ACTIVE,
  parameter int          H_FP     = VGA_H_FP,
  parameter int          H_SYNC   = VGA_H_SYNC,
  parameter int          H_BP     = VGA_H_BP,
  parameter int          V_ACTIVE = VGA_V_ACTIVE,
  parameter int          V_FP     = VGA_V_FP,
  parameter int          V_SYNC   = VGA_V_SYNC,
  parameter int          V_BP     = VGA_V_BP,
  parameter int          X0       = 192,
  parameter int          Y0       = 112,
  parameter int          IMG_W    = 256,
  parameter int          IMG_H    = 256,
  parameter int          SCALE    = 1,
  parameter int          RAM_LAT  = 1,
  parameter int          MODE     = 0,
  parameter int          DATA_W   = 16,
  parameter logic [23:0] BG_RGB   = 24'hFFFFFF,
  parameter int          ADDR_W   = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              hsync,
  output logic              vsync,
  output logic              nblank,
  output logic              nsync,
  output logic [9:0]        x,
  output logic [9:0]        y,
  output logic              frame_start
);

  localparam int          LAT     = RAM_LAT + 2;
  localparam int          CW      = $clog2(IMG_W + 1);
  localparam int          DN      = (DATA_W < 16) ? DATA_W : 16;
  localparam logic [9:0]  X_LO    = 10'(X0);
  localparam logic [9:0]  X_HI    = 10'(X0 + IMG_W * SCALE - 1);
  localparam logic [9:0]  Y_LO    = 10'(Y0);
  localparam logic [9:0]  Y_HI    = 10'(Y0 + IMG_H * SCALE - 1);
  localparam logic [1:0]  SC_LAST = 2'(SCALE - 1);
  localparam pixel_mode_t PMODE   = pixel_mode_t'(2'(MODE));

  if (!(SCALE == 1 || SCALE == 2 || SCALE == 4)) begin : g_bad_scale
    $error("image_window_painter: SCALE must be 1, 2 or 4");
  end
  if ((X0 + IMG_W * SCALE > H_ACTIVE) || (Y0 + IMG_H * SCALE > V_ACTIVE)) begin : g_bad_window
    $error("image_window_painter: window exceeds the active area");
  end
  if ((MODE < 0) || (MODE > 2) || (DATA_W < ((MODE == 2) ? 16 : 8))) begin : g_bad_mode
    $error("image_window_painter: MODE illegal or DATA_W too narrow for MODE");
  end
  if ((RAM_LAT < 1) || (RAM_LAT > 4)) begin : g_bad_lat
    $error("image_window_painter: RAM_LAT must be 1..4");
  end

  logic [9:0] h, v;
  logic       hs_raw, vs_raw, act_raw, line_end, frame_end;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .h        (h),
    .v        (v),
    .hsync    (hs_raw),
    .vsync    (vs_raw),
    .active   (act_raw),
    .line_end (line_end),
    .frame_end(frame_end)
  );

  logic              v_win, in_win;
  logic [CW-1:0]     col_q, col_d;
  logic [1:0]        scol_q, scol_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [1:0]        srow_q, srow_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  side_t             side_q [LAT];
  side_t             side_d [LAT];
  side_t             side_out_stage;
  logic [15:0]       din16;
  logic [23:0]       rgb_q, rgb_d;

  assign v_win  = (v >= Y_LO) && (v <= Y_HI);
  assign in_win = (h >= X_LO) && (h <= X_HI) && v_win;

  // Stage 0 -> 1: incremental address generation, col/row_base track current h/v.
  always_comb begin
    col_d      = col_q;
    scol_d     = scol_q;
    row_base_d = row_base_q;
    srow_d     = srow_q;
    if (in_win) begin
      if (scol_q == SC_LAST) begin
        scol_d = 2'd0;
        col_d  = col_q + 1'b1;
      end else begin
        scol_d = scol_q + 2'd1;
      end
    end else begin
      col_d  = '0;
      scol_d = 2'd0;
    end
    if (frame_end) begin
      row_base_d = '0;
      srow_d     = 2'd0;
    end else if (line_end && v_win) begin
      if (srow_q == SC_LAST) begin
        srow_d     = 2'd0;
        row_base_d = row_base_q + ADDR_W'(IMG_W);
      end else begin
        srow_d = srow_q + 2'd1;
      end
    end
    ram_addr_d = in_win ? (row_base_q + ADDR_W'(col_q)) : '0;
  end

  always_comb begin
    side_d[0].hsync       = hs_raw;
    side_d[0].vsync       = vs_raw;
    side_d[0].nblank      = act_raw;
    side_d[0].frame_start = (h == 10'd0) && (v == 10'd0);
    side_d[0].show        = in_win && en;
    side_d[0].x           = h;
    side_d[0].y           = v;
    for (int i = 1; i < LAT; i++) begin
      side_d[i] = side_q[i-1];
    end
  end

  // Output stage: colour select on RAM data arriving alongside side_q[LAT-2].
  assign side_out_stage = side_q[LAT-2];

  always_comb begin
    din16           = '0;
    din16[DN-1:0]   = ram_rd_data[DN-1:0];
    rgb_d           = BG_RGB;
    if (!side_out_stage.nblank) begin
      rgb_d = '0;
    end else if (side_out_stage.show) begin
      rgb_d = expand_pixel(PMODE, din16);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q      <= '0;
      scol_q     <= '0;
      row_base_q <= '0;
      srow_q     <= '0;
      ram_addr_q <= '0;
      rgb_q      <= '0;
      for (int i = 0; i < LAT; i++) begin
        side_q[i] <= SIDE_IDLE;
      end
    end else begin
      col_q      <= col_d;
      scol_q     <= scol_d;
      row_base_q <= row_base_d;
      srow_q     <= srow_d;
      ram_addr_q <= ram_addr_d;
      rgb_q      <= rgb_d;
      for (int i = 0; i < LAT; i++) begin
        side_q[i] <= side_d[i];
      end
    end
  end

  assign ram_addr    = ram_addr_q;
  assign {r, g, b}   = rgb_q;
  assign hsync       = side_q[LAT-1].hsync;
  assign vsync       = side_q[LAT-1].vsync;
  assign nblank      = side_q[LAT-1].nblank;
  assign frame_start = side_q[LAT-1].frame_start;
  assign x           = side_q[LAT-1].x;
  assign y           = side_q[LAT-1].y;
  assign nsync       = 1'b0;

endmodule

// File: tb/tb_image_window_painter.sv
// Directed bench for image_window_painter on a reduced raster (80x55 total)
// with four instances covering GRAY8 zoom 1/2, RGB565 and RGB332.
module tb_image_window_painter;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_en = 1'b1;
  logic o_en = 1'b1;

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // A: GRAY8, SCALE 1, 16x16 at (16,8), RAM_LAT 1, data = address
  logic [7:0] a_addr, a_rd, a_r, a_g, a_b;
  logic       a_hs, a_vs, a_nb, a_ns, a_fs;
  logic [9:0] a_x, a_y;
  // B: GRAY8, SCALE 2, 8x8 at (16,8), RAM_LAT 2, data = address
  logic [5:0] b_addr;
  logic [7:0] b_p1, b_rd, b_r, b_g, b_b;
  logic       b_hs, b_vs, b_nb, b_ns, b_fs;
  logic [9:0] b_x, b_y;
  // C: RGB565, RAM_LAT 3, constant F800, background 123456
  logic [7:0]  c_addr, c_r, c_g, c_b;
  logic [15:0] c_rd;
  logic        c_hs, c_vs, c_nb, c_ns, c_fs;
  logic [9:0]  c_x, c_y;
  // D: RGB332, RAM_LAT 1, constant 1C
  logic [7:0] d_addr, d_rd, d_r, d_g, d_b;
  logic       d_hs, d_vs, d_nb, d_ns, d_fs;
  logic [9:0] d_x, d_y;

  always @(posedge clk) begin
    a_rd <= a_addr;
    b_p1 <= {2'b00, b_addr};
    b_rd <= b_p1;
  end
  assign c_rd = 16'hF800;
  assign d_rd = 8'h1C;

  image_window_painter #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .X0(16), .Y0(8), .IMG_W(16), .IMG_H(16), .SCALE(1),
    .RAM_LAT(1), .MODE(0), .DATA_W(8), .BG_RGB(24'hFFFFFF)
  ) u_a (
    .clk(clk), .reset(reset), .en(a_en), .ram_rd_data(a_rd), .ram_addr(a_addr),
    .r(a_r), .g(a_g), .b(a_b), .hsync(a_hs), .vsync(a_vs), .nblank(a_nb),
    .nsync(a_ns), .x(a_x), .y(a_y), .frame_start(a_fs)
  );

  image_window_painter #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .X0(16), .Y0(8), .IMG_W(8), .IMG_H(8), .SCALE(2),
    .RAM_LAT(2), .MODE(0), .DATA_W(8), .BG_RGB(24'hFFFFFF)
  ) u_b (
    .clk(clk), .reset(reset), .en(o_en), .ram_rd_data(b_rd), .ram_addr(b_addr),
    .r(b_r), .g(b_g), .b(b_b), .hsync(b_hs), .vsync(b_vs), .nblank(b_nb),
    .nsync(b_ns), .x(b_x), .y(b_y), .frame_start(b_fs)
  );

  image_window_painter #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .X0(16), .Y0(8), .IMG_W(16), .IMG_H(16), .SCALE(1),
    .RAM_LAT(3), .MODE(2), .DATA_W(16), .BG_RGB(24'h123456)
  ) u_c (
    .clk(clk), .reset(reset), .en(o_en), .ram_rd_data(c_rd), .ram_addr(c_addr),
    .r(c_r), .g(c_g), .b(c_b), .hsync(c_hs), .vsync(c_vs), .nblank(c_nb),
    .nsync(c_ns), .x(c_x), .y(c_y), .frame_start(c_fs)
  );

  image_window_painter #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .X0(16), .Y0(8), .IMG_W(16), .IMG_H(16), .SCALE(1),
    .RAM_LAT(1), .MODE(1), .DATA_W(8), .BG_RGB(24'hFFFFFF)
  ) u_d (
    .clk(clk), .reset(reset), .en(o_en), .ram_rd_data(d_rd), .ram_addr(d_addr),
    .r(d_r), .g(d_g), .b(d_b), .hsync(d_hs), .vsync(d_vs), .nblank(d_nb),
    .nsync(d_ns), .x(d_x), .y(d_y), .frame_start(d_fs)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to the cycle where instance A presents pixel (tx,ty).
  task automatic wait_a(input int tx, input int ty);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 6000 && !hit; n++) begin
      @(negedge clk);
      if (a_x == 10'(tx) && a_y == 10'(ty)) hit = 1'b1;
    end
    if (!hit) chk($sformatf("wait_a_%0d_%0d", tx, ty), 32'd0, 32'd1);
  endtask

  // Clocks between two successive falling edges of A's hsync or vsync.
  task automatic sync_period(input bit use_v, input int limit, output int per);
    logic prev, cur;
    int   first;
    per   = -1;
    first = -1;
    prev  = use_v ? a_vs : a_hs;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      cur = use_v ? a_vs : a_hs;
      if (prev && !cur) begin
        if (first < 0) first = n;
        else begin
          per = n - first;
          break;
        end
      end
      prev = cur;
    end
  endtask

  // Counts posedges from a reset release (at a negedge) to each first frame_start.
  task automatic fs_latency(input string tag);
    int fa, fb, fc, fd, a_hi;
    fa = 0; fb = 0; fc = 0; fd = 0; a_hi = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (a_fs) a_hi++;
      if (a_fs && fa == 0) fa = k;
      if (b_fs && fb == 0) fb = k;
      if (c_fs && fc == 0) fc = k;
      if (d_fs && fd == 0) fd = k;
    end
    chk({tag, "_lat_a"}, fa, 3);
    chk({tag, "_lat_b"}, fb, 4);
    chk({tag, "_lat_c"}, fc, 5);
    chk({tag, "_lat_d"}, fd, 3);
    chk({tag, "_pulse_a"}, a_hi, 1);
  endtask

  initial begin
    int per;

    repeat (5) @(negedge clk);
    chk("rst_rgb_a", {a_r, a_g, a_b}, 24'h000000);
    chk("rst_rgb_c", {c_r, c_g, c_b}, 24'h000000);
    chk("rst_ctl_a", {a_hs, a_vs, a_nb, a_fs, a_ns}, 5'b11000);
    chk("rst_xy_a", {a_x, a_y}, 20'd0);
    chk("rst_addr_a", a_addr, 8'd0);
    reset = 1'b1;
    fs_latency("start");

    wait_a(15, 8);
    chk("bg_a_15_8", {a_r, a_g, a_b}, 24'hFFFFFF);
    chk("bg_c_13_8", {c_r, c_g, c_b}, 24'h123456);
    chk("xy_c_13_8", {c_x, c_y}, {10'd13, 10'd8});
    wait_a(16, 8);
    chk("a_16_8", {a_r, a_g, a_b}, 24'h000000);
    chk("d_332_16_8", {d_r, d_g, d_b}, 24'h00FF00);
    wait_a(17, 8);
    chk("a_17_8", {a_r, a_g, a_b}, 24'h010101);
    chk("b_16_8", {b_r, b_g, b_b}, 24'h000000);
    chk("xy_b_16_8", {b_x, b_y}, {10'd16, 10'd8});
    wait_a(18, 8);
    chk("a_18_8", {a_r, a_g, a_b}, 24'h020202);
    chk("b_17_8", {b_r, b_g, b_b}, 24'h000000);
    wait_a(19, 8);
    chk("b_18_8", {b_r, b_g, b_b}, 24'h010101);
    chk("c_565_17_8", {c_r, c_g, c_b}, 24'hFF0000);
    wait_a(32, 8);
    chk("bg_a_32_8", {a_r, a_g, a_b}, 24'hFFFFFF);
    chk("b_31_8", {b_r, b_g, b_b}, 24'h070707);
    chk("c_565_30_8", {c_r, c_g, c_b}, 24'hFF0000);
    wait_a(70, 8);
    chk("a_70_8_ctl", {a_hs, a_nb}, 2'b00);
    chk("a_70_8_rgb", {a_r, a_g, a_b}, 24'h000000);
    wait_a(17, 9);
    chk("a_17_9", {a_r, a_g, a_b}, 24'h111111);
    chk("b_16_9", {b_r, b_g, b_b}, 24'h000000);
    wait_a(17, 10);
    chk("a_17_10", {a_r, a_g, a_b}, 24'h212121);
    chk("b_16_10", {b_r, b_g, b_b}, 24'h080808);

    wait_a(0, 12);
    a_en = 1'b0;
    wait_a(20, 12);
    chk("en_lo_a_20_12", {a_r, a_g, a_b}, 24'hFFFFFF);
    wait_a(67, 12);
    chk("en_lo_hs_67", a_hs, 1'b1);
    wait_a(68, 12);
    chk("en_lo_hs_68", a_hs, 1'b0);
    wait_a(0, 13);
    a_en = 1'b1;
    wait_a(20, 13);
    chk("a_20_13", {a_r, a_g, a_b}, 24'h545454);

    wait_a(30, 23);
    chk("a_30_23", {a_r, a_g, a_b}, 24'hFEFEFE);
    chk("b_29_23", {b_r, b_g, b_b}, 24'h3E3E3E);
    wait_a(32, 23);
    chk("bg_a_32_23", {a_r, a_g, a_b}, 24'hFFFFFF);
    chk("b_last_31_23", {b_r, b_g, b_b}, 24'h3F3F3F);

    sync_period(1'b0, 400, per);
    chk("hsync_period", per, 80);
    sync_period(1'b1, 10000, per);
    chk("vsync_period", per, 4400);

    wait_a(27, 20);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_rgb_a", {a_r, a_g, a_b}, 24'h000000);
    chk("mid_rst_ctl_a", {a_hs, a_vs, a_nb, a_fs}, 4'b1100);
    chk("mid_rst_xy_a", {a_x, a_y}, 20'd0);
    chk("mid_rst_addr_a", a_addr, 8'd0);
    chk("mid_rst_rgb_b", {b_r, b_g, b_b}, 24'h000000);
    reset = 1'b1;
    fs_latency("restart");
    wait_a(17, 9);
    chk("rs_a_17_9", {a_r, a_g, a_b}, 24'h111111);
    wait_a(17, 10);
    chk("rs_b_16_10", {b_r, b_g, b_b}, 24'h080808);
    wait_a(20, 13);
    chk("rs_a_20_13", {a_r, a_g, a_b}, 24'h545454);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/image_window_painter.md
# image_window_painter

Parametrised VGA image painter: generates 640x480-class VGA timing internally and displays an image from an external synchronous pixel RAM inside a configurable window, with integer zoom and selectable pixel format. The RAM read latency is absorbed by a delay pipeline so RGB, sync, blanking and coordinate outputs stay aligned. Everything outside the window shows a parameterised background colour. It sits between the frame-buffer RAM and the board DAC, replacing the fixed-geometry painter.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48: horizontal porch/sync widths
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33: vertical porch/sync widths
- X0, 192 and Y0, 112: window top-left, in active-area pixels
- IMG_W, 256 and IMG_H, 256: stored image size in pixels
- SCALE, 1: integer zoom, legal values 1, 2, 4
- RAM_LAT, 1: RAM read latency in clocks (address registered -> data valid), 1..4
- MODE, 0: 0 = GRAY8, 1 = RGB332, 2 = RGB565
- DATA_W, 16: RAM word width, at least 8 (GRAY8, RGB332) or 16 (RGB565)
- BG_RGB, 24'hFFFFFF: background colour, {r, g, b}
- ADDR_W, $clog2(IMG_W*IMG_H): derived RAM address width
- clk  in  1  pixel clock; one pixel per cycle
- reset  in  1  synchronous, active-low reset
- en  in  1  when low, window shows BG_RGB; timing keeps running
- ram_rd_data  in  DATA_W  RAM read data, valid RAM_LAT clocks after ram_addr
- ram_addr  out  ADDR_W  RAM read address, registered
- r, g, b  out  8 each  pixel colour, registered
- hsync, vsync  out  1  active-low syncs
- nblank  out  1  high during the active area
- nsync  out  1  constant 0
- x, y  out  10 each  coordinates of the pixel currently on r/g/b
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on the outputs

## Operation
- Raw counters h and v: h increments each clock and wraps at H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. v increments on the h wrap and wraps at V_TOTAL-1.
- hsync is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync is defined the same way on v.
- The window is inclusive: X0 <= h <= X0+IMG_W*SCALE-1 and Y0 <= v <= Y0+IMG_H*SCALE-1.
- Address generation is incremental; no multiplier is used.
  - col increments every SCALE window pixels.
  - row_base increments by IMG_W every SCALE window lines and resets to 0 at v = 0.
  - ram_addr = row_base + col. Outside the window, ram_addr holds 0.
- Pixel format conversion:
  - GRAY8: r = g = b = data[7:0].
  - RGB332: r = {d[7:5], d[7:5], d[7:6]}, g = {d[4:2], d[4:2], d[4:3]}, b = {d[1:0] x4}.
  - RGB565: 5- and 6-bit fields are expanded by MSB replication.
- Colour selection: outside the window, or with en low, the pixel is BG_RGB. Outside the active area, r = g = b = 0.
- Illegal parameters are rejected by elaboration assertions: SCALE not in {1, 2, 4}, a window that exceeds the active area, or DATA_W too small for MODE.

## Timing
- Pipeline latency LAT = RAM_LAT + 2 clocks from counter state to outputs.
  - Stage 1 registers ram_addr and in_win.
  - The RAM takes RAM_LAT clocks.
  - The output stage registers r/g/b.
- hsync, vsync, nblank, x, y, in_win and frame_start are delayed through the same LAT-deep shift register, so all outputs are mutually aligned.
- en is sampled at stage 1 and travels with in_win.
- Reset values while reset = 0: h = v = 0, col = row_base = 0, ram_addr = 0, r = g = b = 0, hsync = vsync = 1, nblank = 0, x = y = 0, frame_start = 0, all delay stages cleared.
- Reset mid-frame: on release, the frame restarts at (0,0). The first frame_start appears LAT clocks after release. No partial addresses carry over.
- Frame wrap (h = H_TOTAL-1 and v = V_TOTAL-1 in the same cycle): both counters go to 0, and row_base and col clear in that same cycle.

## Structure
- Package vga_pkg holds:
  - the default timing localparams,
  - the pixel_mode_t enum (GRAY8, RGB332, RGB565),
  - the pixel-expansion functions.
- Sub-module vga_timing_gen contains the h/v counters and raw sync/active decode. Address generation, the delay line and colour mux live in image_window_painter.

## Test plan
- Reset held for 5 clocks, then released: all outputs hold their reset values during reset; first frame_start arrives exactly RAM_LAT+2 clocks after release; hsync period is 800 clocks; vsync period is 420000 clocks.
- RAM model returns data = address[7:0], MODE = GRAY8, SCALE = 1: pixel (192,112) -> r = 0; (193,112) -> 1; (192,113) -> address 256, r = 0; (191,112) -> FF; (448,112) -> FF.
- SCALE = 2, IMG_W = IMG_H = 128: ram_addr repeats each value for 2 pixels and each row for 2 lines; last window pixel (447,367) reads address 16383.
- MODE = RGB565 with data = 16'hF800 -> r = FF, g = 00, b = 00. MODE = RGB332 with data = 8'h1C -> r = 00, g = FF, b = 00.
- en driven low for one full line -> that line shows BG_RGB in the window; sync timing is unchanged.
- reset asserted at v = 200, h = 300 for 1 clock -> outputs clear on the next edge; the frame restarts and the row_base sequence matches the reference model.
